apb_to_ahb_bridge: RTL and testbench

Bridges single APB transfers onto an AHB-Lite-style bus: the block is an APB completer on one side and a single-master AHB initiator on the other. It is the reverse of the team's AHB-to-APB bridge. It lets APB-resident agents (debug, config sequencers) reach AHB memory and peripherals. Each APB transfer becomes exactly one AHB SINGLE word transfer. RETRY/SPLIT are handled by bounded re-issue.

---
 rtl/amba_pkg.sv | 29 ++
 rtl/apb_to_ahb_bridge_if.sv | 40 ++++
 rtl/apb_to_ahb_bridge.sv | 149 ++++++++++++++
 tb/tb_apb_to_ahb_bridge.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amba_pkg.sv
// Shared AMBA types and constants for the AHB/APB bridges.
package amba_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // APB-to-AHB bridge controller states.
    typedef enum logic [1:0] {
        A2H_IDLE,
        A2H_ADDR,
        A2H_DATA,
        A2H_RESP
    } apb2ahb_state_t;

endpackage

// File: rtl/apb_to_ahb_bridge_if.sv
// Bus bundle for the APB-to-AHB bridge: APB completer side plus AHB initiator side.
// slave  : the bridge itself (APB completer, drives the AHB request).
// master : the surroundings (APB requester and AHB target).
interface apb_to_ahb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic [1:0]            HRESP;

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERR,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERR,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/apb_to_ahb_bridge.sv
// APB completer that turns each APB transfer into one AHB SINGLE word transfer,
// with bounded re-issue on RETRY/SPLIT. All outputs are registered.
module apb_to_ahb_bridge
    import amba_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_RETRY  = 4
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    apb_to_ahb_bridge_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRY);

    apb2ahb_state_t        state_q,   state_d;
    logic [CNT_W-1:0]      retry_q,   retry_d;
    logic                  aborted_q, aborted_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [ADDR_WIDTH-1:0] haddr_q,   haddr_d;
    logic                  hwrite_q,  hwrite_d;
    htrans_t               htrans_q,  htrans_d;
    logic [DATA_WIDTH-1:0] hwdata_q,  hwdata_d;
    logic                  pready_q,  pready_d;
    logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
    logic                  pslverr_q, pslverr_d;
    logic                  fin;
    logic                  fin_err;

    assign bus.HADDR   = haddr_q;
    assign bus.HTRANS  = htrans_q;
    assign bus.HWRITE  = hwrite_q;
    assign bus.HSIZE   = HSIZE_WORD;
    assign bus.HBURST  = HBURST_SINGLE;
    assign bus.HWDATA  = hwdata_q;
    assign bus.PREADY  = pready_q;
    assign bus.PRDATA  = prdata_q;
    assign bus.PSLVERR = pslverr_q;

    // Next-state and next-output logic of the transfer controller.
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        aborted_d = aborted_q;
        wdata_d   = wdata_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        htrans_d  = htrans_q;
        hwdata_d  = hwdata_q;
        pready_d  = 1'b0;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        fin       = 1'b0;
        fin_err   = 1'b0;

        case (state_q)
            A2H_IDLE: begin
                aborted_d = 1'b0;
                if (bus.PSEL && !bus.PENABLE) begin
                    haddr_d  = bus.PADDR;
                    hwrite_d = bus.PWRITE;
                    wdata_d  = bus.PWDATA;
                    retry_d  = '0;
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = A2H_ADDR;
                end
            end
            A2H_ADDR: begin
                if (!bus.PSEL) aborted_d = 1'b1;
                if (bus.HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_q;
                    state_d  = A2H_DATA;
                end
            end
            A2H_DATA: begin
                if (!bus.PSEL) aborted_d = 1'b1;
                // HREADY low covers both plain wait states and the first
                // cycle of a two-cycle response: just hold here.
                if (bus.HREADY) begin
                    case (hresp_t'(bus.HRESP))
                        HRESP_OKAY: fin = 1'b1;
                        HRESP_ERROR: begin
                            fin     = 1'b1;
                            fin_err = 1'b1;
                        end
                        default: begin
                            if (retry_q < MAX_CNT) begin
                                retry_d  = retry_q + CNT_W'(1);
                                htrans_d = HTRANS_NONSEQ;
                                state_d  = A2H_ADDR;
                            end else begin
                                fin     = 1'b1;
                                fin_err = 1'b1;
                            end
                        end
                    endcase
                end
            end
            A2H_RESP: state_d = A2H_IDLE;
            default:  state_d = A2H_IDLE;
        endcase

        // A requester that dropped PSEL mid-transfer gets no completion.
        if (fin) begin
            if (aborted_d) begin
                state_d = A2H_IDLE;
            end else begin
                state_d   = A2H_RESP;
                pready_d  = 1'b1;
                pslverr_d = fin_err;
                if (fin_err)        prdata_d = '0;
                else if (!hwrite_q) prdata_d = bus.HRDATA;
            end
        end
    end

    // State and output registers, asynchronously reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= A2H_IDLE;
            retry_q   <= '0;
            aborted_q <= 1'b0;
            wdata_q   <= '0;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            htrans_q  <= HTRANS_IDLE;
            hwdata_q  <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retry_q   <= retry_d;
            aborted_q <= aborted_d;
            wdata_q   <= wdata_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            htrans_q  <= htrans_d;
            hwdata_q  <= hwdata_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

endmodule

// File: tb/tb_apb_to_ahb_bridge.sv
// Scoreboard bench for apb_to_ahb_bridge: an APB driver pushes expected
// completions, an AHB target model serves planned responses, and a monitor
// checks every PREADY against the queue.
module tb_apb_to_ahb_bridge;
    import amba_pkg::*;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int unsigned MAXR = 2;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int unsigned await;
        int unsigned dwait;
    } issue_t;

    typedef struct {
        logic [31:0] prdata;
        logic        pslverr;
    } rsp_t;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    issue_t      plan_q[$];
    rsp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_prdata = '0;
    bit          resp_busy = 1'b0;

    apb_to_ahb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_to_ahb_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_RETRY (MAXR)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus.slave)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_htrans"},  32'(bus.HTRANS),  32'(HTRANS_IDLE));
        check_eq({tag, "_haddr"},   bus.HADDR,        32'h0);
        check_eq({tag, "_hwrite"},  32'(bus.HWRITE),  32'h0);
        check_eq({tag, "_hwdata"},  bus.HWDATA,       32'h0);
        check_eq({tag, "_pready"},  32'(bus.PREADY),  32'h0);
        check_eq({tag, "_prdata"},  bus.PRDATA,       32'h0);
        check_eq({tag, "_pslverr"}, 32'(bus.PSLVERR), 32'h0);
        check_eq({tag, "_hsize"},   32'(bus.HSIZE),   32'h2);
        check_eq({tag, "_hburst"},  32'(bus.HBURST),  32'h0);
    endtask

    // AHB target: serve one NONSEQ issue according to the next plan entry.
    task automatic serve_issue();
        issue_t p;
        resp_busy = 1'b1;
        check_eq("issue_planned", 32'(plan_q.size() != 0), 32'h1);
        if (plan_q.size() == 0) begin
            resp_busy = 1'b0;
            return;
        end
        p = plan_q.pop_front();
        check_eq("haddr", bus.HADDR, p.addr);
        check_eq("hwrite", 32'(bus.HWRITE), 32'(p.write));
        for (int unsigned a = 0; a < p.await; a++) begin
            bus.HREADY = 1'b0;
            @(negedge HCLK);
            check_eq("addr_wait_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        end
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        check_eq("data_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        if (p.write) check_eq("hwdata", bus.HWDATA, p.wdata);
        for (int unsigned w = 0; w < p.dwait; w++) begin
            bus.HREADY = 1'b0;
            bus.HRESP  = HRESP_OKAY;
            bus.HRDATA = $urandom;
            @(negedge HCLK);
            check_eq("wait_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        end
        if (p.resp == HRESP_OKAY) begin
            bus.HREADY = 1'b1;
            bus.HRESP  = HRESP_OKAY;
            bus.HRDATA = p.rdata;
        end else begin
            bus.HREADY = 1'b0;
            bus.HRESP  = p.resp;
            @(negedge HCLK);
            check_eq("resp2_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
            bus.HREADY = 1'b1;
        end
        resp_busy = 1'b0;
    endtask

    // AHB target process.
    initial begin
        bus.HREADY = 1'b1;
        bus.HRESP  = HRESP_OKAY;
        bus.HRDATA = '0;
        forever begin
            @(negedge HCLK);
            bus.HREADY = 1'b1;
            bus.HRESP  = HRESP_OKAY;
            bus.HRDATA = $urandom;
            if (HRESETn && bus.HTRANS == HTRANS_NONSEQ) serve_issue();
        end
    end

    // APB completion monitor.
    initial begin
        rsp_t r;
        forever begin
            @(negedge HCLK);
            if (HRESETn && bus.PREADY === 1'b1) begin
                check_eq("pready_expected", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    r = exp_q.pop_front();
                    check_eq("prdata", bus.PRDATA, r.prdata);
                    check_eq("pslverr", 32'(bus.PSLVERR), 32'(r.pslverr));
                end
            end
        end
    end

    task automatic wait_target_idle(input string tag);
        int unsigned cyc = 0;
        while ((plan_q.size() != 0 || resp_busy) && cyc < 300) begin
            @(negedge HCLK);
            cyc++;
        end
        check_eq({tag, "_target_done"}, 32'(cyc < 300), 32'h1);
    endtask

    // One APB transfer; the expected outcome follows from the planned AHB responses.
    task automatic run_xfer(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int unsigned nretry, input bit final_err,
                            input int unsigned await, input int unsigned dwait, input bit drop);
        int unsigned n_issue;
        int unsigned exp_cycles;
        int unsigned cyc;
        bit          fail;
        rsp_t        r;
        n_issue    = (nretry <= MAXR) ? nretry + 1 : MAXR + 1;
        fail       = (nretry > MAXR) || final_err;
        exp_cycles = 1;
        for (int unsigned i = 0; i < n_issue; i++) begin
            issue_t p;
            p.addr  = addr;
            p.write = write;
            p.wdata = wdata;
            p.rdata = rdata;
            p.await = await;
            p.dwait = dwait;
            if (i + 1 < n_issue || nretry > MAXR)
                p.resp = ($urandom_range(0, 1) == 1) ? HRESP_SPLIT : HRESP_RETRY;
            else
                p.resp = final_err ? HRESP_ERROR : HRESP_OKAY;
            plan_q.push_back(p);
            exp_cycles += 2 + await + dwait + ((p.resp != HRESP_OKAY) ? 1 : 0);
        end
        if (!drop) begin
            r.pslverr    = fail;
            r.prdata     = fail ? 32'h0 : (write ? model_prdata : rdata);
            model_prdata = r.prdata;
            exp_q.push_back(r);
        end
        @(negedge HCLK);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PADDR   = addr;
        bus.PWRITE  = write;
        bus.PWDATA  = wdata;
        @(negedge HCLK);
        if (drop) begin
            bus.PSEL    = 1'b0;
            bus.PENABLE = 1'b0;
            wait_target_idle("drop");
            repeat (3) @(negedge HCLK);
            check_eq("drop_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
            return;
        end
        bus.PENABLE = 1'b1;
        cyc = 1;
        while (bus.PREADY !== 1'b1 && cyc < 300) begin
            @(negedge HCLK);
            cyc++;
        end
        check_eq("latency", cyc, exp_cycles);
        check_eq("issues_left", plan_q.size(), 32'h0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time %0t want completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        issue_t p;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PADDR   = '0;
        bus.PWRITE  = 1'b0;
        bus.PWDATA  = '0;
        repeat (2) @(negedge HCLK);
        check_reset("por");
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // Zero-wait write, then a read with two data-phase waits.
        run_xfer(32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 0, 0, 1'b0);
        run_xfer(32'h0000_2004, 1'b0, 32'h0, 32'h1234_5678, 0, 1'b0, 0, 2, 1'b0);
        // Two-cycle ERROR on a read.
        run_xfer(32'h0000_3008, 1'b0, 32'h0, 32'hCAFE_F00D, 0, 1'b1, 0, 0, 1'b0);
        // Retries up to the limit succeed; one more fails.
        run_xfer(32'h0000_400C, 1'b0, 32'h0, 32'hA5A5_5A5A, MAXR, 1'b0, 0, 0, 1'b0);
        run_xfer(32'h0000_5010, 1'b1, 32'h0BAD_CAFE, 32'h0, MAXR + 1, 1'b0, 0, 1, 1'b0);
        // Write leaves PRDATA holding the last read.
        run_xfer(32'h0000_5014, 1'b0, 32'h0, 32'h7777_1111, 0, 1'b0, 1, 0, 1'b0);
        run_xfer(32'h0000_5018, 1'b1, 32'h1357_9BDF, 32'h0, 0, 1'b0, 0, 0, 1'b0);

        // Reset while the data phase is stalled.
        p.addr  = 32'h0000_6000;
        p.write = 1'b0;
        p.wdata = 32'h0;
        p.rdata = 32'hFFFF_0000;
        p.resp  = HRESP_OKAY;
        p.await = 0;
        p.dwait = 6;
        plan_q.push_back(p);
        @(negedge HCLK);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PADDR   = p.addr;
        bus.PWRITE  = 1'b0;
        @(negedge HCLK);
        bus.PENABLE = 1'b1;
        repeat (2) @(negedge HCLK);
        HRESETn     = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        #1;
        check_reset("mid");
        model_prdata = '0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        wait_target_idle("rst");
        run_xfer(32'h0000_6004, 1'b0, 32'h0, 32'h2468_ACE0, 0, 1'b0, 0, 0, 1'b0);

        // Requester drops PSEL during the address phase.
        run_xfer(32'h0000_7000, 1'b0, 32'h0, 32'h9999_8888, 0, 1'b0, 0, 1, 1'b1);
        run_xfer(32'h0000_7004, 1'b1, 32'h4242_4242, 32'h0, 0, 1'b0, 0, 0, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            int unsigned nr;
            nr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAXR + 1) : 0;
            run_xfer($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom, nr,
                     ($urandom_range(0, 4) == 0), $urandom_range(0, 1), $urandom_range(0, 2), 1'b0);
        end

        repeat (4) @(negedge HCLK);
        check_eq("exp_queue_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
